pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 5, meaning total pipeline depth (IF..WB); legal range 4..8.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register-address width.
REQ-003 SHALL have parameter ZERO_REG, default 31, meaning hard-wired zero register (XZR); never a hazard source.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports clk and reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 id_valid  input  1  valid instruction in decode (ID).
REQ-008 id_rn, id_rb  input  ADDR_W each  ID source register addresses (rb = Reg2Loc-selected Rm/Rd).
REQ-009 id_use_rn, id_use_rb  input  1 each  ID actually reads that source.
REQ-010 id_rd  input  ADDR_W  ID destination register.
REQ-011 id_regwrite, id_is_load, id_setflag, id_use_flags  input  1 each  ID control: writes reg, is LDUR, sets flags (ADDS/SUBS), reads flags (B.cond).
REQ-012 ex_br_taken  input  1  branch resolved taken in EX this cycle.
REQ-013 stall  output  1  hold PC and IF/ID register; combinational.
REQ-014 flush  output  1  clear IF/ID register; combinational.
REQ-015 fwd_a_sel, fwd_b_sel  output  FW=$clog2(NSTAGE-1) each  registered forwarding select for the instruction now in EX; 0 = regfile, k = result held in tag stage k+1.
REQ-016 stall_cnt, flush_cnt  output  16 each  saturating event counters.

Function
REQ-017 SHALL hold tag registers T[1..NSTAGE-2] (T[1]=EX ... T[NSTAGE-2]=WB), each {valid, rd, regwrite, is_load, setflag}.
REQ-018 Each edge: T[k+1] <= T[k] for all k; T[1] <= ID tag with valid = id_valid & ~stall & ~flush; otherwise a bubble (valid=0).
REQ-019 Source match: id_use_x & source==T[k].rd & T[k].valid & T[k].regwrite & T[k].rd!=ZERO_REG.
REQ-020 Load-use: stall=1 when id_valid and any source matches T[1] with T[1].is_load=1.
REQ-021 Flag hazard: stall=1 when id_valid & id_use_flags & T[1].valid & T[1].setflag.
REQ-022 flush = ex_br_taken; when flush=1, stall SHALL be 0 (flush has priority).
REQ-023 Forward select computed in ID: smallest k in 1..NSTAGE-2 with a match (youngest producer wins), registered into fwd_x_sel on an edge without stall; sel=0 when no match, stall, or flush.
REQ-024 During stall, fwd_x_sel SHALL be 0 (bubble in EX).
REQ-025 stall_cnt increments on each edge with stall=1; flush_cnt on each edge with flush=1; both saturate at 16'hFFFF.
REQ-026 A matching producer in T[1] that is not a load SHALL yield forwarding (sel=1), not a stall.
REQ-027 Latency: hazard outputs combinational same cycle; fwd_x_sel valid one cycle after ID evaluation.

Reset
REQ-028 Reset SHALL asynchronously clear all T[k].valid, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt to 0; stall and flush then follow inputs combinationally (0 with idle inputs).
REQ-029 Reset asserted mid-stall or mid-flush SHALL abort the event; first post-reset instruction sees no hazard.

Structure
REQ-030 Package pipe_pkg SHALL hold the tag struct typedef, ZERO_REG default, and the FW width function.
REQ-031 One sub-module pipe_tag_reg (async-reset tag register with bubble input) SHALL be instantiated NSTAGE-2 times via generate.

Verification (NSTAGE=5)
REQ-032 ADDS X1 then ADD X2,X1,X5 back-to-back -> stall=0, fwd_a_sel=1 next cycle, fwd_b_sel=0.
REQ-033 LDUR X3 then ADD X4,X3,X3 -> stall=1 one cycle, stall_cnt=1; then fwd_a_sel=fwd_b_sel=2.
REQ-034 ADDI X31 then ADD X6,X31,X31 -> no stall, fwd sels 0.
REQ-035 Load-use hazard with ex_br_taken=1 same cycle -> flush=1, stall=0, flush_cnt+1, T[1] bubble.
REQ-036 SUBS then B.LT -> stall=1 one cycle; reset asserted during stall -> all outputs/counters 0 immediately.
REQ-037 Force 65536 stall edges -> stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared types and helpers for the pipeline hazard controller.
//            - tag_t      : per-stage producer tag {valid, rd, regwrite,
//                           is_load, setflag}
//            - ZERO_REG_DEFAULT : index of the hard-wired zero register (XZR)
//            - fw_width() : width of the forwarding-select outputs
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int ZERO_REG_DEFAULT = 31;

  // Tag destination field is sized for the widest supported register file.
  // Narrower ADDR_W values are zero-extended into it, so ADDR_W must not
  // exceed TAG_ADDR_W.
  localparam int TAG_ADDR_W = 8;

  typedef struct packed {
    logic                  valid;
    logic [TAG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  is_load;
    logic                  setflag;
  } tag_t;

  // Select values run 0..NSTAGE-2, hence NSTAGE-1 distinct codes.
  function automatic int fw_width(input int nstage);
    return $clog2(nstage - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_tag_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_tag_reg
// Purpose  : One pipeline-stage producer tag register with bubble insertion.
// Ports    : clk    - rising-edge clock
//            reset  - asynchronous active-high reset (clears the tag)
//            bubble - load the tag with valid forced low
//            d      - incoming tag from the previous stage
//            q      - registered tag for this stage
// Revision : 1.0 - initial release
// ============================================================================
module pipe_tag_reg
  import pipe_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic bubble,
  input  tag_t d,
  output tag_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      q       <= d;
      q.valid <= d.valid & ~bubble;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Hazard detection and forwarding control for an in-order
//            NSTAGE-deep pipeline. Tracks producer tags for stages EX..WB,
//            raises stall on load-use and flag hazards, flush on a taken
//            branch, and registers forwarding selects for the instruction
//            entering EX.
// Ports    : clk, reset                  - clock, async active-high reset
//            id_valid                    - valid instruction in ID
//            id_rn, id_rb, id_use_rn/rb  - ID sources and their use flags
//            id_rd, id_regwrite, id_is_load, id_setflag, id_use_flags
//                                        - ID destination and control
//            ex_br_taken                 - branch resolved taken in EX
//            stall, flush                - combinational hazard outputs
//            fwd_a_sel, fwd_b_sel        - registered forwarding selects
//                                          (0 = regfile, k = tag stage k+1)
//            stall_cnt, flush_cnt        - saturating event counters
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NSTAGE   = 5,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = ZERO_REG_DEFAULT,
  localparam int FW      = fw_width(NSTAGE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rn,
  input  logic [ADDR_W-1:0] id_rb,
  input  logic              id_use_rn,
  input  logic              id_use_rb,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic              id_setflag,
  input  logic              id_use_flags,
  input  logic              ex_br_taken,
  output logic              stall,
  output logic              flush,
  output logic [FW-1:0]     fwd_a_sel,
  output logic [FW-1:0]     fwd_b_sel,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  localparam int NTAG = NSTAGE - 2;

  tag_t    tag_q   [1:NTAG];
  tag_t    tag_d   [1:NTAG];
  logic    tag_bub [1:NTAG];
  tag_t    id_tag;
  logic    load_use;
  logic    flag_haz;
  logic [FW-1:0] sel_a_nxt;
  logic [FW-1:0] sel_b_nxt;
  logic    unused_tag_flags;

  function automatic logic src_match(input logic              use_src,
                                     input logic [ADDR_W-1:0] src,
                                     input tag_t              t);
    return use_src && t.valid && t.regwrite &&
           (t.rd == TAG_ADDR_W'(src)) &&
           (t.rd != TAG_ADDR_W'(ZERO_REG));
  endfunction

  always_comb begin
    id_tag          = '0;
    id_tag.valid    = id_valid;
    id_tag.rd       = TAG_ADDR_W'(id_rd);
    id_tag.regwrite = id_regwrite;
    id_tag.is_load  = id_is_load;
    id_tag.setflag  = id_setflag;
  end

  // Only T[1] (EX) can create a stall: anything older is forwardable.
  assign load_use = id_valid && tag_q[1].is_load &&
                    (src_match(id_use_rn, id_rn, tag_q[1]) ||
                     src_match(id_use_rb, id_rb, tag_q[1]));
  assign flag_haz = id_valid && id_use_flags && tag_q[1].valid && tag_q[1].setflag;

  // Flush wins: the ID instruction is being discarded anyway.
  assign flush = ex_br_taken;
  assign stall = (load_use | flag_haz) & ~flush;

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    sel_a_nxt = '0;
    sel_b_nxt = '0;
    for (int k = NTAG; k >= 1; k--) begin
      if (src_match(id_use_rn, id_rn, tag_q[k])) sel_a_nxt = FW'(k);
      if (src_match(id_use_rb, id_rb, tag_q[k])) sel_b_nxt = FW'(k);
    end
    if (!id_valid) begin
      sel_a_nxt = '0;
      sel_b_nxt = '0;
    end
  end

  // Load/flag attributes only matter in EX; older stages carry them along.
  always_comb begin
    unused_tag_flags = 1'b0;
    for (int k = 2; k <= NTAG; k++) begin
      unused_tag_flags = unused_tag_flags ^ tag_q[k].is_load ^ tag_q[k].setflag;
    end
  end

  for (genvar k = 1; k <= NTAG; k++) begin : g_tag
    if (k == 1) begin : g_head
      assign tag_d[k]   = id_tag;
      assign tag_bub[k] = stall | flush;
    end else begin : g_body
      assign tag_d[k]   = tag_q[k-1];
      assign tag_bub[k] = 1'b0;
    end

    pipe_tag_reg u_tag (
      .clk    (clk),
      .reset  (reset),
      .bubble (tag_bub[k]),
      .d      (tag_d[k]),
      .q      (tag_q[k])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_a_sel <= '0;
      fwd_b_sel <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      // A stalled or flushed ID slot becomes a bubble in EX.
      if (stall || flush) begin
        fwd_a_sel <= '0;
        fwd_b_sel <= '0;
      end else begin
        fwd_a_sel <= sel_a_nxt;
        fwd_b_sel <= sel_b_nxt;
      end
      if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (flush && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire
